instr_mem_port: RTL and testbench

INSTR_MEM_PORT -- requirements
Module: instr_mem_port

---
 rtl/instr_mem_port_pkg.sv | 13 +
 rtl/instr_ram_1r1w.sv | 23 ++
 rtl/instr_mem_port.sv | 130 +++++++++++++
 tb/tb_instr_mem_port.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_port_pkg.sv
// Shared core definitions for the instruction memory port: bubble word and
// the port's run/load/drain state encoding.
package instr_mem_port_pkg;

    localparam logic [31:0] CORE_NOP_WORD = 32'h00000013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } mem_state_e;

endpackage

// File: rtl/instr_ram_1r1w.sv
// Instruction storage: one synchronous read port, one write port, no reset
// on contents so a reset never wipes a loaded program.
module instr_ram_1r1w #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/instr_mem_port.sv
// Fetch-side instruction memory port: one-cycle synchronous fetch into the
// decode register, plus a streaming program loader that stalls the core.
module instr_mem_port
    import instr_mem_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = CORE_NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         if_pc_next,
    input  logic                de_stall,
    input  logic                de_flush,
    output logic [31:0]         de_instr,
    output logic                de_fault,
    output logic                mem_busy,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [31:0]         ld_data,
    output logic                ld_ready,
    input  logic                ld_last,
    output logic [ADDR_WIDTH:0] ld_count
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    mem_state_e          state_q;
    logic [ADDR_WIDTH:0] ld_cnt_q;
    logic                ld_ready_q, mem_busy_q;
    logic                sel_nop_q, sel_nop_d, fault_q, fault_d;
    logic                run, pc_bad, accept, at_end, rd_en;
    logic [31:0]         ram_rdata;

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign accept = ld_valid & ld_ready_q;
    assign at_end = accept & (ld_last | (ld_cnt_q == LAST_ADDR));

    // The load counter doubles as the write pointer; the extra MSB means
    // it reaches 2**ADDR_WIDTH instead of wrapping.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= RUN;
            ld_cnt_q   <= '0;
            ld_ready_q <= 1'b0;
            mem_busy_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (ld_start) begin
                    state_q    <= LOAD;
                    ld_cnt_q   <= '0;
                    ld_ready_q <= 1'b1;
                    mem_busy_q <= 1'b1;
                end
                LOAD: begin
                    if (accept) ld_cnt_q <= ld_cnt_q + (ADDR_WIDTH+1)'(1);
                    if (at_end) begin
                        state_q    <= DRAIN;
                        ld_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    state_q    <= RUN;
                    mem_busy_q <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    ld_ready_q <= 1'b0;
                    mem_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign run    = (state_q == RUN);
    assign pc_bad = (|if_pc_next[1:0]) | (|if_pc_next[31:ADDR_WIDTH+2]);
    // A stalled read leaves the RAM output register untouched, which is the hold.
    assign rd_en  = !(run && de_stall);

    always_comb begin
        sel_nop_d = sel_nop_q;
        fault_d   = fault_q;
        if (!run || de_flush) begin
            sel_nop_d = 1'b1;
            fault_d   = 1'b0;
        end else if (!de_stall) begin
            sel_nop_d = pc_bad;
            fault_d   = pc_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sel_nop_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            sel_nop_q <= sel_nop_d;
            fault_q   <= fault_d;
        end
    end

    instr_ram_1r1w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (ld_cnt_q[ADDR_WIDTH-1:0]),
        .wr_data_i (ld_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (if_pc_next[ADDR_WIDTH+1:2]),
        .rd_data_o (ram_rdata)
    );

    // Bubble is forced for the whole session; the DRAIN update leaves a
    // bubble for the first RUN cycle so no pre-load word escapes.
    assign de_instr = (!run || sel_nop_q) ? NOP_WORD : ram_rdata;
    assign de_fault = run & fault_q;
    assign ld_ready = ld_ready_q;
    assign mem_busy = mem_busy_q;
    assign ld_count = ld_cnt_q;

endmodule

// File: tb/tb_instr_mem_port.sv
// Directed bench: table of fetch vectors plus hand-written load sessions.
module tb_instr_mem_port;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, de_stall, de_flush, ld_start, ld_valid, ld_last;
    logic [31:0] if_pc_next, ld_data, de_instr;
    logic        de_fault, mem_busy, ld_ready;
    logic [10:0] ld_count;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int rdy_cnt = 0;
    int busy_base, rdy_base;
    logic [31:0] ld_buf [1024];

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;
    vec_t vecs [17];

    instr_mem_port #(.ADDR_WIDTH(10), .NOP_WORD(32'h00000013)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_pc_next (if_pc_next),
        .de_stall   (de_stall),
        .de_flush   (de_flush),
        .de_instr   (de_instr),
        .de_fault   (de_fault),
        .mem_busy   (mem_busy),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_last    (ld_last),
        .ld_count   (ld_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        busy_cnt <= busy_cnt + int'(mem_busy);
        rdy_cnt  <= rdy_cnt + int'(ld_ready);
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Returns in the DRAIN cycle (one edge after the final accepted word).
    task automatic load_session(input int n, input bit use_last, input int gap_at,
                                input bit start_in_gap);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("load_forces_nop", de_instr, NOP);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                ld_valid = 1'b0;
                ld_start = start_in_gap;
                tick();
                ld_start = 1'b0;
            end
            ld_valid = 1'b1;
            ld_data  = ld_buf[i];
            ld_last  = use_last && (i == n - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; de_stall = 1'b0; de_flush = 1'b0; if_pc_next = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;

        vecs[0]  = '{32'h0000_0014, 1'b0, 1'b0, 32'h00A00093, 1'b0};
        vecs[1]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0000_0101, 1'b0};
        vecs[2]  = '{32'h0000_0008, 1'b1, 1'b0, 32'h0000_0101, 1'b0};
        vecs[3]  = '{32'h0000_000C, 1'b1, 1'b0, 32'h0000_0101, 1'b0};
        vecs[4]  = '{32'h0000_0010, 1'b1, 1'b0, 32'h0000_0101, 1'b0};
        vecs[5]  = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0104, 1'b0};
        vecs[6]  = '{32'h0000_0008, 1'b1, 1'b1, NOP,           1'b0};
        vecs[7]  = '{32'h0000_0008, 1'b1, 1'b0, NOP,           1'b0};
        vecs[8]  = '{32'h0000_0016, 1'b0, 1'b0, NOP,           1'b1};
        vecs[9]  = '{32'h0000_0008, 1'b1, 1'b0, NOP,           1'b1};
        vecs[10] = '{32'h0000_1000, 1'b0, 1'b0, NOP,           1'b1};
        vecs[11] = '{32'h0000_0FFC, 1'b0, 1'b0, 32'hA500_03FF, 1'b0};
        vecs[12] = '{32'h0000_0FFC, 1'b0, 1'b1, NOP,           1'b0};
        vecs[13] = '{32'h0000_0018, 1'b0, 1'b0, 32'hA500_0006, 1'b0};
        vecs[14] = '{32'h0000_0001, 1'b0, 1'b0, NOP,           1'b1};
        vecs[15] = '{32'h8000_0000, 1'b0, 1'b0, NOP,           1'b1};
        vecs[16] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_instr", de_instr, NOP);
        chk("rst_fault", {31'b0, de_fault}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd0);
        chk("rst_count", {21'b0, ld_count}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Full-array load without ld_last: auto-drain after word 1023
        for (int i = 0; i < 1024; i++) ld_buf[i] = 32'hA500_0000 | 32'(i);
        busy_base = busy_cnt; rdy_base = rdy_cnt;
        load_session(1024, 1'b0, -1, 1'b0);
        chk("full_count", {21'b0, ld_count}, 32'd1024);
        chk("full_drain_busy", {31'b0, mem_busy}, 32'd1);
        chk("full_drain_ready", {31'b0, ld_ready}, 32'd0);
        chk("full_drain_instr", de_instr, NOP);
        tick();
        chk("full_run_busy", {31'b0, mem_busy}, 32'd0);
        chk("full_run_ready", {31'b0, ld_ready}, 32'd0);
        chk("full_busy_cycles", 32'(busy_cnt - busy_base), 32'd1025);
        chk("full_ready_cycles", 32'(rdy_cnt - rdy_base), 32'd1024);
        tick();
        chk("full_ready_after", {31'b0, ld_ready}, 32'd0);
        chk("full_count_hold", {21'b0, ld_count}, 32'd1024);

        // Six-word session terminated by ld_last; word 5 = addi x1,x0,10
        for (int i = 0; i < 5; i++) ld_buf[i] = 32'h0000_0100 + 32'(i);
        ld_buf[5] = 32'h00A00093;
        load_session(6, 1'b1, -1, 1'b0);
        chk("s1_count", {21'b0, ld_count}, 32'd6);
        tick();

        // Table-driven fetch vectors
        for (int i = 0; i < 17; i++) begin
            if_pc_next = vecs[i].pc;
            de_stall   = vecs[i].stall;
            de_flush   = vecs[i].flush;
            tick();
            chk($sformatf("vec%0d_instr", i), de_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_fault", i), {31'b0, de_fault}, {31'b0, vecs[i].exp_fault});
        end
        de_stall = 1'b0; de_flush = 1'b0;

        // Four words with a gap; a stray ld_start in the gap must be ignored
        if_pc_next = 32'h14;
        tick();
        chk("s4_pre_instr", de_instr, 32'h00A00093);
        de_stall = 1'b1;
        ld_buf[0] = 32'h11; ld_buf[1] = 32'h22; ld_buf[2] = 32'h33; ld_buf[3] = 32'h44;
        busy_base = busy_cnt; rdy_base = rdy_cnt;
        load_session(4, 1'b1, 2, 1'b1);
        de_stall = 1'b0;
        chk("s4_count", {21'b0, ld_count}, 32'd4);
        chk("s4_drain_instr", de_instr, NOP);
        tick();
        chk("s4_first_run_nop", de_instr, NOP);
        chk("s4_busy_cycles", 32'(busy_cnt - busy_base), 32'd6);
        chk("s4_ready_cycles", 32'(rdy_cnt - rdy_base), 32'd5);
        if_pc_next = 32'h0C;
        tick();
        chk("s4_fetch_0c", de_instr, 32'h44);
        chk("s4_fetch_fault", {31'b0, de_fault}, 32'd0);
        chk("s4_count_hold", {21'b0, ld_count}, 32'd4);

        // Reset in the middle of a session
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hDEAD_0000;
        tick();
        ld_data = 32'hDEAD_0001;
        tick();
        ld_valid = 1'b0;
        chk("s5_count_pre", {21'b0, ld_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("s5_busy", {31'b0, mem_busy}, 32'd0);
        chk("s5_ready", {31'b0, ld_ready}, 32'd0);
        chk("s5_count", {21'b0, ld_count}, 32'd0);
        chk("s5_instr", de_instr, NOP);
        tick();
        rst_n = 1'b1;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("s5_sync_ignores_start", {31'b0, mem_busy}, 32'd0);
        repeat (2) tick();
        chk("s5_still_run", {31'b0, mem_busy}, 32'd0);
        if_pc_next = 32'h0;
        tick();
        chk("s5_word0", de_instr, 32'hDEAD_0000);
        if_pc_next = 32'h4;
        tick();
        chk("s5_word1", de_instr, 32'hDEAD_0001);
        if_pc_next = 32'h8;
        tick();
        chk("s5_word2_kept", de_instr, 32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
